// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per IRWrite edge over a req/ack
// handshake and latches it into the instruction register for the main controller.
module instr_fetch_unit #(
  parameter int unsigned       XLEN         = 32,
  parameter int unsigned       OPCODE_WIDTH = 7,
  parameter logic [XLEN-1:0]   RESET_PC     = '0,
  parameter logic [XLEN-1:0]   NOP_INSTR    = XLEN'(32'h13),
  parameter int unsigned       MEM_TIMEOUT  = 15
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_pc_write,
  input  logic                    i_ir_write,
  input  logic [XLEN-1:0]         i_pc_next,
  output logic                    o_mem_req,
  output logic [XLEN-1:0]         o_mem_addr,
  input  logic [XLEN-1:0]         i_mem_rdata,
  input  logic                    i_mem_ack,
  output logic [XLEN-1:0]         o_pc,
  output logic [XLEN-1:0]         o_instr,
  output logic [OPCODE_WIDTH-1:0] o_op_code,
  output logic                    o_instr_valid,
  output logic                    o_fetch_busy,
  output logic                    o_fetch_fault,
  output logic                    o_misalign_fault
);

  localparam int unsigned CntW = 4;

  typedef enum logic [0:0] {
    StIdle,
    StReq
  } state_e;

  state_e            r_state, w_state_next;
  logic              r_irw_d;
  logic [CntW-1:0]   r_cnt, w_cnt_next;
  logic              r_mem_req, w_mem_req_next;
  logic [XLEN-1:0]   r_mem_addr, w_mem_addr_next;
  logic [XLEN-1:0]   r_instr, w_instr_next;
  logic              r_instr_valid, w_instr_valid_next;
  logic              r_fetch_fault, w_fetch_fault_next;
  logic [XLEN-1:0]   r_pc, w_pc_next;
  logic              r_misalign, w_misalign_next;

  logic              w_start;
  logic              w_timeout;

  // The controller holds IRWrite for several states; only its rising edge starts a fetch.
  assign w_start   = i_ir_write & ~r_irw_d;
  assign w_timeout = (r_cnt == CntW'(MEM_TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_irw_d       <= 1'b0;
      r_cnt         <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_pc          <= RESET_PC;
      r_misalign    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_irw_d       <= i_ir_write;
      r_cnt         <= w_cnt_next;
      r_mem_req     <= w_mem_req_next;
      r_mem_addr    <= w_mem_addr_next;
      r_instr       <= w_instr_next;
      r_instr_valid <= w_instr_valid_next;
      r_fetch_fault <= w_fetch_fault_next;
      r_pc          <= w_pc_next;
      r_misalign    <= w_misalign_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_mem_req_next     = r_mem_req;
    w_mem_addr_next    = r_mem_addr;
    w_instr_next       = r_instr;
    w_instr_valid_next = 1'b0;
    w_fetch_fault_next = r_fetch_fault;

    unique case (r_state)
      StIdle: begin
        // Captures the PC before any same-cycle PCWrite takes effect.
        if (w_start) begin
          w_state_next    = StReq;
          w_mem_req_next  = 1'b1;
          w_mem_addr_next = r_pc;
          w_cnt_next      = '0;
        end
      end
      StReq: begin
        if (i_mem_ack) begin
          w_instr_next       = i_mem_rdata;
          w_instr_valid_next = 1'b1;
          w_mem_req_next     = 1'b0;
          w_state_next       = StIdle;
        end else if (w_timeout) begin
          w_fetch_fault_next = 1'b1;
          w_mem_req_next     = 1'b0;
          w_state_next       = StIdle;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
    endcase
  end

  // PC updates in any state; an in-flight fetch keeps its captured address.
  always_comb begin
    w_pc_next       = r_pc;
    w_misalign_next = r_misalign;
    if (i_pc_write) begin
      w_pc_next = {i_pc_next[XLEN-1:2], 2'b00};
      if (i_pc_next[1:0] != 2'b00) begin
        w_misalign_next = 1'b1;
      end
    end
  end

  assign o_mem_req        = r_mem_req;
  assign o_mem_addr       = r_mem_addr;
  assign o_pc             = r_pc;
  assign o_instr          = r_instr;
  assign o_op_code        = r_instr[OPCODE_WIDTH-1:0];
  assign o_instr_valid    = r_instr_valid;
  assign o_fetch_busy     = (r_state == StReq);
  assign o_fetch_fault    = r_fetch_fault;
  assign o_misalign_fault = r_misalign;

endmodule
